// File: rtl/shift_pipe_if.sv
// shift_pipe_if -- operand/result handshake bundle for shift_pipe.
//   master : producer/consumer side (drives operands, flush, out_ready)
//   slave  : the shifter (drives in_ready, out_valid, out_data)
// Signals:
//   flush              invalidate every pipeline stage on the next edge
//   in_valid/in_ready  operand handshake; in_data, in_shamt, in_op
//                      (op: 00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   out_valid/out_ready result handshake; out_data
interface shift_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output flush, in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  flush, in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe -- fully pipelined barrel shifter (SLL/SRL/SRA/ROR).
// One register stage per shift level; stage k shifts by 2^k when shamt
// bit k is set, least significant level first. The whole pipe advances
// together when the output slot is empty or being drained.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_pipe_if.slave (operand, result and flush signals)

// One combinational shift level: conditionally shift by 2^LVL.
module shift_stage #(
    parameter int WIDTH = 32,
    parameter int LVL   = 0
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic             sh_i,
    output logic [WIDTH-1:0] data_o
);
    localparam int D = 1 << LVL;

    logic [WIDTH-1:0] sll, srl, sra, ror;

    always_comb begin
        sll = {data_i[WIDTH-1-D:0], {D{1'b0}}};
        srl = {{D{1'b0}}, data_i[WIDTH-1:D]};
        // Earlier right shifts never change the MSB, so the current MSB
        // is still the operand's sign.
        sra = {{D{data_i[WIDTH-1]}}, data_i[WIDTH-1:D]};
        ror = {data_i[D-1:0], data_i[WIDTH-1:D]};
        data_o = data_i;
        if (sh_i) begin
            case (op_i)
                2'b00:   data_o = sll;
                2'b01:   data_o = srl;
                2'b10:   data_o = sra;
                default: data_o = ror;
            endcase
        end
    end
endmodule

module shift_pipe #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_pipe_if.slave bus
);
    // Stage register k keeps only the shamt bits still needed downstream
    // (bits k+1..SHW-1), packed triangularly into one flat vector.
    localparam int REM_W = SHW * (SHW - 1) / 2;

    function automatic int rem_idx(input int k, input int j);
        return k * (SHW - 1) - (k * (k - 1)) / 2 + (j - k - 1);
    endfunction

    logic                      en;
    logic [SHW-1:0]            vld_pipe_d, vld_pipe_q;
    logic [SHW-1:0][WIDTH-1:0] data_d, data_q;
    logic [SHW-2:0][1:0]       op_d, op_q;
    logic [REM_W-1:0]          rem_d, rem_q, rem_nxt;

    logic [SHW-1:0][WIDTH-1:0] stg_in, stg_out;
    logic [SHW-1:0][1:0]       stg_op;
    logic [SHW-1:0]            stg_sh;

    assign en            = ~vld_pipe_q[SHW-1] | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];

    for (genvar k = 0; k < SHW; k++) begin : g_stg
        if (k == 0) begin : g_src
            assign stg_in[k] = bus.in_data;
            assign stg_op[k] = bus.in_op;
            assign stg_sh[k] = bus.in_shamt[0];
            for (genvar j = 1; j < SHW; j++) begin : g_rem
                assign rem_nxt[rem_idx(0, j)] = bus.in_shamt[j];
            end
        end else begin : g_src
            assign stg_in[k] = data_q[k-1];
            assign stg_op[k] = op_q[k-1];
            assign stg_sh[k] = rem_q[rem_idx(k-1, k)];
            for (genvar j = k + 1; j < SHW; j++) begin : g_rem
                assign rem_nxt[rem_idx(k, j)] = rem_q[rem_idx(k-1, j)];
            end
        end

        shift_stage #(.WIDTH(WIDTH), .LVL(k)) u_stage (
            .data_i (stg_in[k]),
            .op_i   (stg_op[k]),
            .sh_i   (stg_sh[k]),
            .data_o (stg_out[k])
        );
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        data_d     = data_q;
        op_d       = op_q;
        rem_d      = rem_q;
        if (en) begin
            // in_ready == en, so S0 valid is simply in_valid here.
            vld_pipe_d = {vld_pipe_q[SHW-2:0], bus.in_valid};
            if (!bus.flush) begin
                data_d = stg_out;
                op_d   = stg_op[SHW-2:0];
                rem_d  = rem_nxt;
            end
        end
        // Flush kills every valid bit regardless of en; payload is held.
        if (bus.flush) vld_pipe_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            data_q     <= '0;
            op_q       <= '0;
            rem_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            data_q     <= data_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
        end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe -- directed and model-checked bench for shift_pipe (WIDTH=32).
// Inputs change 1ns after the rising edge; everything is sampled on the
// falling edge. A scoreboard queue holds expected results in acceptance
// order, with the offer cycle for latency checks.
module tb_shift_pipe;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_pipe_if #(.WIDTH(WIDTH)) bus ();

    shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] e;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        h;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_waits;
    logic [31:0] exp_in;
    bit          lat_mode, rnd_rdy, rnd_bit, rdy_man;
    bit          vld_seen;

    assign bus.out_ready = rnd_rdy ? rnd_bit : rdy_man;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                          input logic [1:0] op);
        logic [63:0] dd;
        dd = {d, d};
        case (op)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return 32'($signed(d) >>> s);
            default: return dd[s +: 32];
        endcase
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    h = exp_q.pop_front();
                    chk("data", bus.out_data, h.e);
                    if (h.lat) chk("latency", 32'(cyc - h.cyc), 32'd5);
                end
            end
            if (bus.flush) exp_q.delete();
            else if (bus.in_valid && bus.in_ready) exp_q.push_back('{exp_in, cyc, lat_mode});
        end
    end

    // Called 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                        input logic [31:0] e);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_op    = op;
        exp_in       = e;
        last_waits   = 0;
        while (!ok && last_waits < 100) begin
            @(negedge clk);
            last_waits++;
            ok = bus.in_ready;
        end
        if (!ok) chk("send_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_no_valid(input string tag);
        vld_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            vld_seen |= bus.out_valid;
        end
        chk(tag, 32'(vld_seen), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_shamt = '0;
        bus.in_op    = '0;
        exp_in       = '0;
        rdy_man      = 1'b1;
        rnd_rdy      = 1'b0;
        lat_mode     = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data,       32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Per-op directed values, 5-cycle latency
        lat_mode = 1'b1;
        send(32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000);
        send(32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001);
        send(32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000);
        send(32'h1234_5678, 5'd8,  2'd3, 32'h7812_3456);
        send(32'h7FFF_FFFF, 5'd31, 2'd2, 32'h0000_0000);
        send(32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF);
        send(32'hFFFF_FFFF, 5'd16, 2'd0, 32'hFFFF_0000);
        send(32'hF000_0000, 5'd28, 2'd1, 32'h0000_000F);
        send(32'h8000_0001, 5'd1,  2'd3, 32'hC000_0000);
        drain();

        // Back-to-back stream, shamt 0: identity, in_ready never drops
        send(32'hA5A5_A5A5, 5'd0, 2'd0, 32'hA5A5_A5A5); chk("stream_rdy", 32'(last_waits), 32'd1);
        send(32'h8000_0000, 5'd0, 2'd2, 32'h8000_0000); chk("stream_rdy", 32'(last_waits), 32'd1);
        send(32'h1234_5678, 5'd0, 2'd3, 32'h1234_5678); chk("stream_rdy", 32'(last_waits), 32'd1);
        send(32'hFFFF_FFFF, 5'd0, 2'd1, 32'hFFFF_FFFF); chk("stream_rdy", 32'(last_waits), 32'd1);
        send(32'h0000_0001, 5'd0, 2'd0, 32'h0000_0001); chk("stream_rdy", 32'(last_waits), 32'd1);
        send(32'hDEAD_BEEF, 5'd0, 2'd2, 32'hDEAD_BEEF); chk("stream_rdy", 32'(last_waits), 32'd1);
        send(32'h0F0F_0F0F, 5'd0, 2'd3, 32'h0F0F_0F0F); chk("stream_rdy", 32'(last_waits), 32'd1);
        send(32'h7FFF_FFFF, 5'd0, 2'd1, 32'h7FFF_FFFF); chk("stream_rdy", 32'(last_waits), 32'd1);
        drain();

        // Backpressure: freeze a full pipe for 10 cycles
        lat_mode = 1'b0;
        for (int i = 0; i < 6; i++) send(32'(i + 1), 5'd4, 2'd0, 32'((i + 1) * 16));
        rdy_man      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_00FF;
        bus.in_shamt = 5'd8;
        bus.in_op    = 2'd0;
        exp_in       = 32'h0000_FF00;
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_data",  bus.out_data,       32'h0000_0020);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(posedge clk);
        #1 rdy_man = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        // Reference sweep with random backpressure
        rnd_rdy = 1'b1;
        for (int op = 0; op < 4; op++)
            for (int s = 0; s < 32; s++)
                for (int r = 0; r < 8; r++) begin
                    logic [31:0] d;
                    d = $urandom;
                    send(d, 5'(s), 2'(op), model(d, 5'(s), 2'(op)));
                end
        drain();
        rnd_rdy = 1'b0;

        // Flush with 3 results in flight; operand offered with flush is dropped
        lat_mode = 1'b1;
        send(32'h1111_1111, 5'd1, 2'd0, 32'h2222_2222);
        send(32'h2222_2222, 5'd1, 2'd1, 32'h1111_1111);
        send(32'h3333_3333, 5'd2, 2'd3, 32'hCCCC_CCCC);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_FFFF;
        bus.in_shamt = 5'd0;
        exp_in       = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        idle_no_valid("flush_no_valid");
        send(32'h0000_1234, 5'd4, 2'd0, 32'h0001_2340);
        drain();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) send(32'(i + 1), 5'd4, 2'd3, 32'(i + 1) << 28);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data",  bus.out_data,       32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_no_valid("rst_no_stale");
        send(32'h8000_0000, 5'd1, 2'd2, 32'hC000_0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, fully pipelined barrel shifter for the 32-bit MIPS datapath and its wider variants. It performs logical left, logical right, arithmetic right and rotate right by a variable amount. Each shift level is one register stage: level k conditionally shifts by 2^k, least significant level first. A valid/ready handshake with global stall lets it sit between the register-read and write-back stages of the multi-cycle and pipelined datapaths.

## Interface
- WIDTH, 32: data width; power of two, at least 4.
- SHW, log2(WIDTH): shift-amount width and number of pipeline stages; derived, not overridden.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; when 1, invalidates every stage on the next edge.
- in_valid  input  1  input operand is valid.
- in_ready  output  1  stage 0 can accept this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, unsigned, 0..WIDTH-1.
- in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  shifted result.

## Operation
- Pipeline of SHW stages, S0..S(SHW-1).
  - Each stage register holds valid, data, op and the remaining shamt bits.
  - Stage k receives the data from stage k-1, or in_data for k=0.
  - If shamt bit k is 1, stage k shifts that data by 2^k according to op; otherwise it passes the data unchanged.
- Fill value for each op:
  - SLL: vacated low bits filled with 0.
  - SRL: vacated high bits filled with 0.
  - SRA: vacated high bits filled with the operand's bit WIDTH-1. The sign is unchanged by earlier right shifts, so each stage uses its current MSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
- shamt 0: the result equals the operand for every op.
- No width extension; the result is always WIDTH bits.
- Advance enable: en = ~out_valid | out_ready.
  - When en=1, all stages load from their predecessor in the same cycle.
  - S0 loads valid=in_valid & in_ready.
  - A bubble (valid=0) propagates like data.
  - When en=0, all stages hold their contents.
- in_ready = en. This is combinational from out_valid and out_ready; there is no combinational path from in_valid.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Results leave in acceptance order. No reordering and no dropping, except on flush or reset.
- flush:
  - On the next edge, all valid bits are cleared, regardless of en.
  - A transfer offered in the flush cycle is discarded.
  - Data and shamt registers keep their contents.
- Data registers of invalid stages are don't-care. The bench must not check out_data while out_valid=0.

## Timing
- Reset (rst_n=0, asynchronous):
  - All stage valid bits and all data, op and shamt registers go to 0.
  - out_valid=0, out_data=0, in_ready=1.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+SHW-1. That is SHW cycles from the cycle it was offered (5 for WIDTH=32).
- Throughput: one result per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, the whole pipe freezes and out_data is stable.
  - in_ready=0 while frozen.
  - Results already in the pipe resume in order, without loss, once out_ready returns to 1.
- Simultaneous output transfer and input transfer in the same cycle is legal and is the steady state.
- Reset asserted mid-operation: every in-flight result is lost. The first output after reset release is the first operand accepted after release.
- flush and rst_n=0 together: reset wins.

## Test plan
All scenarios use WIDTH=32.
- Per-op values with out_ready=1:
  - SLL 0x00000001 by 31 -> 0x80000000.
  - SRL 0x80000000 by 31 -> 0x00000001.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - ROR 0x12345678 by 8 -> 0x78123456.
  - Each result arrives exactly 5 cycles after it was offered.
- Stream and shamt=0:
  - 8 back-to-back operands with shamt 0 and mixed ops; every output equals its input, in order, one per cycle, with in_ready held at 1.
  - SRA 0x7FFFFFFF by 31 -> 0x00000000.
- Backpressure:
  - Hold out_ready=0 for 10 cycles while a stream is in flight.
  - out_data stays stable and in_ready=0 throughout.
  - After release, all 5 in-flight results emerge in order, followed by any later input.
- Exhaustive reference check: all 4 ops × all 32 shamts on random operands (at least 1000 vectors) match a behavioural model; out_ready is randomly toggled.
- Flush mid-stream: with 3 results in flight, assert flush for one cycle. No out_valid appears for those 3; the next operand offered returns correctly after 5 cycles.
- Reset mid-stream: drive rst_n low asynchronously between edges.
  - out_valid and out_data go to 0 immediately, and in_ready=1.
  - After release, no stale results emerge.
